// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC, nop word and word alignment.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: FETCH/HOLD/DROP FSM over a ready-handshake instruction memory.
// Optional counters fetchCount/bubbleCount are built when IF_FETCH_PERF_EN is defined.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic [31:0] pcAdd4IF,
    output logic [31:0] instructionIF,
    output logic        fetchBusy
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] bubbleCount
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_hold_instr;

    logic         w_req;
    logic [31:0]  w_addr;
    logic         w_busy;
    logic [31:0]  w_instr;
    logic [31:0]  w_pc_add4;
    logic [31:0]  w_target;
    logic         w_consume;

    assign w_pc_add4 = r_pc + 32'd4;
    assign w_target  = align_word(redirectTarget);

    // The presented word is consumed only when neither redirect nor stall holds it back.
    assign w_consume = !redirect && !stall &&
                       (((r_state == FETCH) && imemReady) || (r_state == HOLD));

    always_comb begin
        w_req   = 1'b0;
        w_addr  = r_pc;
        w_busy  = 1'b1;
        w_instr = NOP_INSTR;
        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (imemReady && !redirect) begin
                    w_busy  = 1'b0;
                    w_instr = imemRdata;
                end
            end
            HOLD: begin
                if (!redirect) begin
                    w_busy  = 1'b0;
                    w_instr = r_hold_instr;
                end
            end
            DROP: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirect) begin
                        r_pc <= w_target;
                        // A request already on the bus must still complete; remember its address.
                        if (!imemReady) begin
                            r_req_addr <= r_pc;
                            r_state    <= DROP;
                        end
                    end else if (imemReady) begin
                        if (stall) begin
                            r_hold_instr <= imemRdata;
                            r_state      <= HOLD;
                        end else begin
                            r_pc <= w_pc_add4;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_target;
                        r_state <= FETCH;
                    end else if (!stall) begin
                        r_pc    <= w_pc_add4;
                        r_state <= FETCH;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        r_pc <= w_target;
                    end
                    if (imemReady) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imemReq       = w_req;
    assign imemAddr      = w_addr;
    assign fetchBusy     = w_busy;
    assign instructionIF = w_instr;
    assign pcAdd4IF      = w_pc_add4;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count  <= 32'd0;
            r_bubble_count <= 32'd0;
        end else begin
            if (w_consume) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_busy) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign fetchCount  = r_fetch_count;
    assign bubbleCount = r_bubble_count;
`else
    logic w_consume_unused;
    assign w_consume_unused = w_consume;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed cycle vectors push expectations, a monitor pops and compares.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic [31:0] pcAdd4IF;
    logic [31:0] instructionIF;
    logic        fetchBusy;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] bubbleCount;
`endif

    if_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemReady      (imemReady),
        .imemRdata      (imemRdata),
        .pcAdd4IF       (pcAdd4IF),
        .instructionIF  (instructionIF),
        .fetchBusy      (fetchBusy)
`ifdef IF_FETCH_PERF_EN
        ,
        .fetchCount     (fetchCount),
        .bubbleCount    (bubbleCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: every word is its address XOR a tag, so a wrong address shows as a wrong word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imemRdata = mem_word(imemAddr);

    typedef struct {
        logic        busy;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pca4;
    } cyc_t;

    cyc_t        cq[$];
    logic [31:0] iq[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus its hand-computed expected outputs.
    task automatic vec(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy,
                       input logic ebusy, input logic ereq, input logic [31:0] eaddr,
                       input logic [31:0] epca, input logic [31:0] einstr);
        cyc_t c;
        @(negedge clk);
        stall          = st;
        redirect       = rd;
        redirectTarget = tgt;
        imemReady      = rdy;
        c.busy = ebusy;
        c.req  = ereq;
        c.addr = eaddr;
        c.pca4 = epca;
        cq.push_back(c);
        if (!ebusy) iq.push_back(einstr);
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives.
    task automatic do_reset();
        @(negedge clk);
        stall     = 1'b0;
        redirect  = 1'b0;
        imemReady = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_req", {31'd0, imemReq}, 32'd1);
        chk("rst_addr", imemAddr, 32'h0);
        chk("rst_pca4", pcAdd4IF, 32'h4);
        chk("rst_busy", {31'd0, fetchBusy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        cyc_t c;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() != 0) begin
                c = cq.pop_front();
                $display("cyc busy=%b req=%b addr=%h pca4=%h instr=%h",
                         fetchBusy, imemReq, imemAddr, pcAdd4IF, instructionIF);
                chk("busy", {31'd0, fetchBusy}, {31'd0, c.busy});
                chk("req", {31'd0, imemReq}, {31'd0, c.req});
                if (c.req) chk("addr", imemAddr, c.addr);
                chk("pca4", pcAdd4IF, c.pca4);
                if (!fetchBusy) begin
                    if (iq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL instr: got %h with no word expected", instructionIF);
                    end else begin
                        chk("instr", instructionIF, iq.pop_front());
                    end
                end else begin
                    chk("nop", instructionIF, NOP_INSTR);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirectTarget = 32'h0;
        imemReady      = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("init_req", {31'd0, imemReq}, 32'd1);
        chk("init_addr", imemAddr, 32'h0);
        chk("init_pca4", pcAdd4IF, 32'h4);
        @(negedge clk);
        reset = 1'b0;

        // Zero-wait memory: one instruction per cycle.
        vec(0, 0, 32'h0, 1, 0, 1, 32'h0, 32'h4,  mem_word(32'h0));
        vec(0, 0, 32'h0, 1, 0, 1, 32'h4, 32'h8,  mem_word(32'h4));
        vec(0, 0, 32'h0, 1, 0, 1, 32'h8, 32'hC,  mem_word(32'h8));
        vec(0, 0, 32'h0, 1, 0, 1, 32'hC, 32'h10, mem_word(32'hC));
        do_reset();

        vec(0, 0, 32'h0, 1, 0, 1, 32'h0, 32'h4, mem_word(32'h0));
        vec(0, 0, 32'h0, 1, 0, 1, 32'h4, 32'h8, mem_word(32'h4));
        // Stall three cycles as the word at 0x8 returns, then release.
        vec(1, 0, 32'h0, 1, 0, 1, 32'h8, 32'hC, mem_word(32'h8));
        vec(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'hC, mem_word(32'h8));
        vec(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'hC, mem_word(32'h8));
        vec(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'hC, mem_word(32'h8));
        vec(0, 0, 32'h0, 1, 0, 1, 32'hC, 32'h10, mem_word(32'hC));
        // Two wait states at 0x10.
        vec(0, 0, 32'h0, 0, 1, 1, 32'h10, 32'h14, 32'h0);
        vec(0, 0, 32'h0, 0, 1, 1, 32'h10, 32'h14, 32'h0);
        vec(0, 0, 32'h0, 1, 0, 1, 32'h10, 32'h14, mem_word(32'h10));
        // Redirect to 0x40 while 0x14 is outstanding.
        vec(0, 1, 32'h40, 0, 1, 1, 32'h14, 32'h18, 32'h0);
        vec(0, 0, 32'h0,  0, 1, 1, 32'h14, 32'h44, 32'h0);
        vec(0, 0, 32'h0,  1, 1, 1, 32'h14, 32'h44, 32'h0);
        vec(0, 0, 32'h0,  1, 0, 1, 32'h40, 32'h44, mem_word(32'h40));
        // Redirect plus stall in HOLD, wrap at the top of memory, unaligned target.
        vec(1, 0, 32'h0,         1, 0, 1, 32'h44, 32'h48, mem_word(32'h44));
        vec(1, 1, 32'hFFFFFFFF,  0, 1, 0, 32'h0,  32'h48, 32'h0);
        vec(0, 0, 32'h0,         1, 0, 1, 32'hFFFFFFFC, 32'h0, mem_word(32'hFFFFFFFC));
        vec(0, 1, 32'h43,        1, 1, 1, 32'h0,  32'h4,  32'h0);
        vec(0, 0, 32'h0,         1, 0, 1, 32'h40, 32'h44, mem_word(32'h40));
        // Second redirect while draining only moves the PC.
        vec(0, 1, 32'h80,  0, 1, 1, 32'h44, 32'h48,  32'h0);
        vec(0, 1, 32'h100, 0, 1, 1, 32'h44, 32'h84,  32'h0);
        vec(0, 0, 32'h0,   1, 1, 1, 32'h44, 32'h104, 32'h0);
        vec(0, 0, 32'h0,   1, 0, 1, 32'h100, 32'h104, mem_word(32'h100));
        // Reset while draining restarts cleanly from 0.
        vec(0, 1, 32'h200, 0, 1, 1, 32'h104, 32'h108, 32'h0);
        do_reset();
        vec(0, 0, 32'h0, 1, 0, 1, 32'h0, 32'h4, mem_word(32'h0));

`ifdef IF_FETCH_PERF_EN
        // Ten fetches; bubbles are the reset-release cycle plus two wait states.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 7)
                vec(0, 0, 32'h0, 0, 1, 1, 32'(4 * k), 32'(4 * k + 4), 32'h0);
            vec(0, 0, 32'h0, 1, 0, 1, 32'(4 * k), 32'(4 * k + 4), mem_word(32'(4 * k)));
        end
        @(negedge clk);
        imemReady = 1'b0;
        #2;
        chk("fetchCount", fetchCount, 32'd10);
        chk("bubbleCount", bubbleCount, 32'd3);
`endif

        repeat (2) @(negedge clk);
        #3;
        n_vec++;
        if (iq.size() != 0 || cq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d words %0d cycles pending expected 0", iq.size(), cq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
